countdown_timer: RTL

BCD minutes:seconds countdown timer for the clock kit. It is the counting-down counterpart of the up-counting minute/hour chain.
- The user sets a duration with increment buttons.
- Each 1 Hz enable tick then decrements the value through a BCD borrow chain.
- At 00:00 it raises an alarm for a programmable number of ticks.

Digit outputs feed the same 7-segment display path as the clock counters.

---
 rtl/countdown_timer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer: button-set duration, 1 Hz decrement, timed alarm at 00:00.
// IDLE/RUN/PAUSE/ALM control with all display and status outputs registered.
module countdown_timer #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       START,
  input  logic       CLR,
  input  logic       MINUP,
  input  logic       SECUP,
  output logic [2:0] MH,
  output logic [3:0] ML,
  output logic [2:0] SH,
  output logic [3:0] SL,
  output logic       RUNNING,
  output logic       ALARM
);

  localparam int unsigned CNT_W = $clog2(ALARM_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALM   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ticks;

  logic [2:0] inc_mh, inc_sh, dec_mh, dec_sh;
  logic [3:0] inc_ml, inc_sl, dec_ml, dec_sl;
  logic       is_zero, is_one;

  // Mod-60 increments for the set buttons; minutes and seconds are independent.
  always_comb begin
    inc_sh = SH;
    inc_sl = SL + 4'd1;
    if (SL == 4'd9) begin
      inc_sl = 4'd0;
      inc_sh = (SH == 3'd5) ? 3'd0 : SH + 3'd1;
    end
    inc_mh = MH;
    inc_ml = ML + 4'd1;
    if (ML == 4'd9) begin
      inc_ml = 4'd0;
      inc_mh = (MH == 3'd5) ? 3'd0 : MH + 3'd1;
    end
  end

  // One-second BCD borrow chain; never applied at 00:00.
  always_comb begin
    dec_mh = MH;
    dec_ml = ML;
    dec_sh = SH;
    dec_sl = SL - 4'd1;
    if (SL == 4'd0) begin
      dec_sl = 4'd9;
      if (SH == 3'd0) begin
        dec_sh = 3'd5;
        if (ML == 4'd0) begin
          dec_ml = 4'd9;
          dec_mh = MH - 3'd1;
        end else begin
          dec_ml = ML - 4'd1;
        end
      end else begin
        dec_sh = SH - 3'd1;
      end
    end
  end

  assign is_zero = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd0);
  assign is_one  = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      ticks   <= '0;
      MH      <= 3'd0;
      ML      <= 4'd0;
      SH      <= 3'd0;
      SL      <= 4'd0;
      RUNNING <= 1'b0;
      ALARM   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR) begin
            MH <= 3'd0; ML <= 4'd0; SH <= 3'd0; SL <= 4'd0;
          end else if (START) begin
            if (!is_zero) begin
              state   <= RUN;
              RUNNING <= 1'b1;
            end
          end else begin
            if (SECUP) begin SH <= inc_sh; SL <= inc_sl; end
            if (MINUP) begin MH <= inc_mh; ML <= inc_ml; end
          end
        end

        RUN: begin
          if (CLR) begin
            MH <= 3'd0; ML <= 4'd0; SH <= 3'd0; SL <= 4'd0;
            state   <= IDLE;
            RUNNING <= 1'b0;
          end else if (START) begin
            state   <= PAUSE;
            RUNNING <= 1'b0;
          end else if (EN) begin
            MH <= dec_mh; ML <= dec_ml; SH <= dec_sh; SL <= dec_sl;
            if (is_one) begin
              state   <= ALM;
              ticks   <= '0;
              RUNNING <= 1'b0;
              ALARM   <= 1'b1;
            end
          end
        end

        PAUSE: begin
          if (CLR) begin
            MH <= 3'd0; ML <= 4'd0; SH <= 3'd0; SL <= 4'd0;
            state <= IDLE;
          end else if (START) begin
            if (is_zero) begin
              state <= IDLE;
            end else begin
              state   <= RUN;
              RUNNING <= 1'b1;
            end
          end else begin
            if (SECUP) begin SH <= inc_sh; SL <= inc_sl; end
            if (MINUP) begin MH <= inc_mh; ML <= inc_ml; end
          end
        end

        ALM: begin
          if (CLR || START) begin
            state <= IDLE;
            ALARM <= 1'b0;
          end else if (EN) begin
            ticks <= ticks + CNT_W'(1);
            if (ticks + CNT_W'(1) == CNT_W'(ALARM_TICKS)) begin
              state <= IDLE;
              ALARM <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          RUNNING <= 1'b0;
          ALARM   <= 1'b0;
        end
      endcase
    end
  end

endmodule
